// File: rtl/chip8_loader.sv
// Receive-side program loader: parses SYNC/LEN/payload/CSUM frames from the UART
// byte stream, writes the payload into program memory and holds the CPU meanwhile.
module chip8_loader #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BASE_ADDR      = 512,
    parameter logic [7:0]  SYNC_BYTE      = 8'hC8,
    parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_i,
    input  logic                  rx_i_v,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_d,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [1:0]            err_code
);

    localparam int unsigned MAX_LEN = (1 << ADDR_WIDTH) - BASE_ADDR;
    localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
    // Loaded with TIMEOUT_CYCLES-1 and expiring at 1, so load_err lands exactly
    // TIMEOUT_CYCLES cycles after the last accepted byte.
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    generate
        if (DATA_WIDTH != 8) begin : g_bad_data_width
            $error("chip8_loader: DATA_WIDTH must be 8");
        end
        if (BASE_ADDR >= (1 << ADDR_WIDTH)) begin : g_bad_base_addr
            $error("chip8_loader: BASE_ADDR outside the address space");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CSUM
    } state_t;

    state_t                  state_reg, state_next;
    logic [7:0]              len_hi_reg, len_hi_next;
    logic [15:0]             len_reg, len_next;
    logic [15:0]             index_reg, index_next;
    logic [7:0]              csum_reg, csum_next;
    logic [TW-1:0]           timer_reg, timer_next;
    logic                    mem_we_reg, mem_we_next;
    logic [ADDR_WIDTH-1:0]   mem_waddr_reg, mem_waddr_next;
    logic [DATA_WIDTH-1:0]   mem_d_reg, mem_d_next;
    logic                    cpu_hold_reg, cpu_hold_next;
    logic                    load_done_reg, load_done_next;
    logic                    load_err_reg, load_err_next;
    logic [1:0]              err_code_reg, err_code_next;

    logic [15:0]             len_full;
    logic                    len_bad;

    assign len_full = {len_hi_reg, rx_i};
    assign len_bad  = (len_full == 16'd0) || (32'(len_full) > MAX_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            len_hi_reg    <= '0;
            len_reg       <= '0;
            index_reg     <= '0;
            csum_reg      <= '0;
            timer_reg     <= '0;
            mem_we_reg    <= 1'b0;
            mem_waddr_reg <= ADDR_WIDTH'(BASE_ADDR);
            mem_d_reg     <= '0;
            cpu_hold_reg  <= 1'b0;
            load_done_reg <= 1'b0;
            load_err_reg  <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else begin
            state_reg     <= state_next;
            len_hi_reg    <= len_hi_next;
            len_reg       <= len_next;
            index_reg     <= index_next;
            csum_reg      <= csum_next;
            timer_reg     <= timer_next;
            mem_we_reg    <= mem_we_next;
            mem_waddr_reg <= mem_waddr_next;
            mem_d_reg     <= mem_d_next;
            cpu_hold_reg  <= cpu_hold_next;
            load_done_reg <= load_done_next;
            load_err_reg  <= load_err_next;
            err_code_reg  <= err_code_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        len_hi_next    = len_hi_reg;
        len_next       = len_reg;
        index_next     = index_reg;
        csum_next      = csum_reg;
        timer_next     = timer_reg;
        mem_we_next    = 1'b0;
        mem_waddr_next = mem_waddr_reg;
        mem_d_next     = mem_d_reg;
        cpu_hold_next  = cpu_hold_reg;
        load_done_next = 1'b0;
        load_err_next  = 1'b0;
        err_code_next  = err_code_reg;

        if (rx_i_v) begin
            // An accepted byte always restarts the inter-byte timer, even on the expiry cycle.
            timer_next = TIMER_RELOAD;
            case (state_reg)
                ST_IDLE: begin
                    if (rx_i == SYNC_BYTE) begin
                        state_next    = ST_LEN_H;
                        cpu_hold_next = 1'b1;
                        err_code_next = ERR_NONE;
                    end
                end
                ST_LEN_H: begin
                    len_hi_next = rx_i;
                    state_next  = ST_LEN_L;
                end
                ST_LEN_L: begin
                    if (len_bad) begin
                        load_err_next = 1'b1;
                        err_code_next = ERR_LEN;
                        state_next    = ST_IDLE;
                    end else begin
                        len_next   = len_full;
                        index_next = '0;
                        csum_next  = '0;
                        state_next = ST_DATA;
                    end
                end
                ST_DATA: begin
                    mem_we_next    = 1'b1;
                    mem_waddr_next = ADDR_WIDTH'(BASE_ADDR + 32'(index_reg));
                    mem_d_next     = DATA_WIDTH'(rx_i);
                    csum_next      = csum_reg + rx_i;
                    index_next     = index_reg + 16'd1;
                    if (index_reg + 16'd1 == len_reg) begin
                        state_next = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (rx_i == csum_reg) begin
                        load_done_next = 1'b1;
                        cpu_hold_next  = 1'b0;
                    end else begin
                        load_err_next = 1'b1;
                        err_code_next = ERR_CSUM;
                    end
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end else if (state_reg != ST_IDLE) begin
            if (timer_reg <= TW'(1)) begin
                load_err_next = 1'b1;
                err_code_next = ERR_TIMEOUT;
                state_next    = ST_IDLE;
            end else begin
                timer_next = timer_reg - TW'(1);
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_waddr = mem_waddr_reg;
    assign mem_d     = mem_d_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign load_done = load_done_reg;
    assign load_err  = load_err_reg;
    assign err_code  = err_code_reg;

endmodule
